uart_fifo: RTL and testbench
============================

# uart_fifo

Parametrised, buffered UART peripheral for the AZ bus. It replaces the single-byte UART with transmit and receive FIFOs, a runtime-programmable baud divisor, optional parity, and error/overrun reporting. It sits on the same chip-select bus slot and raises the same two level interrupts toward the interrupt controller.

## Interface
- FIFO_DEPTH, 16: entries per FIFO. Power of two, 2..128.
- DIV_W, 16: width of the baud divisor register.
- DEFAULT_DIV, 434: reset divisor, in clocks per bit (50 MHz / 115200).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cs_  in  1  chip select, active low.
- as_  in  1  address strobe, active low.
- rw  in  1  1 = read, 0 = write.
- addr  in  2  register select.
- wr_data  in  32  write data.
- rd_data  out  32  read data; valid while rdy_=0, otherwise 0.
- rdy_  out  1  ready, active low.
- irq_rx  out  1  receive interrupt, level.
- irq_tx  out  1  transmit interrupt, level.
- rd_data_u  in  1  serial RX line, asynchronous.
- wr_data_u  out  1  serial TX line, idles high.

## Operation
- **Bus access:** an access is accepted on every clk edge where cs_=0 and as_=0. rdy_=0 and rd_data are registered, and are valid for exactly one cycle after the access. Side effects occur once per accepted cycle.
- **addr 0, STATUS (read):**
  - [0] rx_not_empty
  - [1] tx_not_full
  - [2] tx_idle (TX FIFO empty and shifter idle)
  - [3] rx_overrun
  - [4] frame_err
  - [5] parity_err
  - [15:8] rx_count
  - [23:16] tx_count
  - All other bits 0.
- **addr 0, STATUS (write):** a 1 in wr_data[5:3] clears the corresponding sticky flag (write-1-to-clear).
- **addr 1, DATA (write):** pushes wr_data[7:0] into the TX FIFO. If the FIFO is full, the byte is silently dropped.
- **addr 1, DATA (read):** pops the RX FIFO and returns {24'b0, byte}. If the FIFO is empty, it returns 0 and does not pop.
- **addr 2, DIVISOR:** R/W, DIV_W bits. A written value below 4 is stored as 4. A new value takes effect at the next bit boundary of each shifter.
- **addr 3, CTRL:** R/W, [3:0] = {par_odd, par_en, tx_ie, rx_ie}, reset 0.
- **Frame format:** start bit (0), 8 data bits LSB first, optional parity bit (even, or odd if par_odd), one stop bit (1).
- **TX FSM:** IDLE → START → DATA(×8) → [PARITY if par_en] → STOP → IDLE.
  - Each non-IDLE state lasts exactly div clocks.
  - IDLE pops the TX FIFO and enters START when the FIFO is non-empty.
  - STOP returns to IDLE, or goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
- **RX path:** a 2-FF synchroniser feeds the FSM. RX FSM: IDLE → START → DATA(×8) → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised 0 enters START.
  - START: samples at div/2 (integer floor). If the sample is 1, it is a false start and the FSM returns to IDLE.
  - DATA, PARITY, STOP: each sample is taken div clocks after the previous one.
- **RX stop-bit handling:**
  - Stop sampled 0: set frame_err, discard the byte.
  - Parity mismatch: set parity_err, discard the byte.
  - Otherwise push the byte. If the RX FIFO is full, set rx_overrun and drop the new byte.
- **FIFO behaviour:** simultaneous push and pop in the same cycle both take effect and the count is unchanged. The "full" condition (count == FIFO_DEPTH) is evaluated before the same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs that cycle. Read and write pointers wrap modulo FIFO_DEPTH.
- **Interrupts:** irq_rx = rx_ie & rx_not_empty. irq_tx = tx_ie & tx_idle. Both are registered.
- **CTRL changes:** changing par_en mid-frame takes effect from the next frame.

## Timing
- **Reset values:** rd_data=0, rdy_=1, irq_rx=0, irq_tx=0, wr_data_u=1. FIFOs are empty, flags 0, CTRL 0, divisor DEFAULT_DIV.
- **Reset mid-frame:** aborts both frames immediately; wr_data_u goes to 1 asynchronously.
- **Bus read latency:** 1 cycle (access at edge N, data valid at edge N+1).
- **TX latency:** a DATA write at edge N with the FIFO empty and the shifter idle drives wr_data_u low at edge N+2.
- **Frame length:** 10·div clocks, or 11·div with parity.
- **RX latency:** rx_not_empty rises 1 cycle after the STOP sample. RX input adds 2 cycles of synchroniser delay.
- **Interrupt latency:** irq_* lag their source condition by 1 cycle.

## Test plan
- Reset, then read STATUS → 0x00000006 (tx_not_full, tx_idle), with rdy_=0 one cycle after the access. Read addr 2 → 434.
- Set DIVISOR=8 and write 0xA5 to DATA → wr_data_u shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit held 8 clocks. tx_idle returns to 1 after the stop bit.
- Loop wr_data_u to rd_data_u with DIVISOR=8, par_en=1, par_odd=1, and send 0x3C → read DATA = 0x3C, parity_err=0. Set rx_ie=1 → irq_rx is high until the read, then low 1 cycle after.
- Write 17 bytes with FIFO_DEPTH=16 while the shifter is busy → tx_count=16 and tx_not_full=0 (count taken before the shifter's first pop). 16 frames are transmitted and the 17th byte never appears.
- Inject 17 frames with no reads → rx_count=16, rx_overrun=1. Writing 0x08 to STATUS clears rx_overrun. Sixteen DATA reads return the first 16 bytes in order; a 17th read returns 0.
- Inject a frame with stop=0 → frame_err=1 and rx_count unchanged. Inject a 0.25-bit low glitch → no frame is received and no flags change.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART peripheral for the AZ bus.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   cs_, as_   chip select / address strobe, both active low
//   rw         1 = read, 0 = write
//   addr       register select: 0 STATUS, 1 DATA, 2 DIVISOR, 3 CTRL
//   wr_data    bus write data
//   rd_data    registered read data, valid while rdy_ = 0, else 0
//   rdy_       active-low ready, one cycle after every accepted access
//   irq_rx     level interrupt: rx_ie & rx_not_empty
//   irq_tx     level interrupt: tx_ie & tx_idle
//   rd_data_u  serial RX line (asynchronous)
//   wr_data_u  serial TX line, idles high
//
// Frame FSM states (shared by TX and RX):
//   state    | meaning
//   S_IDLE   | line idle, waiting for a byte (TX) or a falling edge (RX)
//   S_START  | start bit
//   S_DATA   | eight data bits, LSB first
//   S_PARITY | optional parity bit
//   S_STOP   | stop bit

module uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // full is judged before any same-cycle pop, so a push to a full FIFO drops
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (!push_ok && pop_ok) count <= count - CW'(1);
        end
    end
endmodule

module uart_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq_rx,
    output logic        irq_tx,
    input  logic        rd_data_u,
    output logic        wr_data_u
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} frame_state_t;

    // ---------------- bus decode and registers ----------------
    logic             acc;
    logic [DIV_W-1:0] div_reg;
    logic [3:0]       ctrl;
    logic             rx_overrun, frame_err, parity_err;
    logic [31:0]      rd_mux;
    logic             unused_wr_bits;

    assign acc            = ~cs_ & ~as_;
    assign unused_wr_bits = ^wr_data;

    logic          tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout, rx_sh;
    logic [CW-1:0] rx_count;

    assign tx_push = acc & ~rw & (addr == 2'd1);
    assign rx_pop  = acc &  rw & (addr == 2'd1);

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .din(wr_data[7:0]), .dout(tx_dout), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .dout(rx_dout), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd0: rd_mux = {8'b0, 8'(tx_count), 8'(rx_count), 2'b0, parity_err,
                            frame_err, rx_overrun, tx_idle, ~tx_full, ~rx_empty};
            2'd1: rd_mux = rx_empty ? 32'b0 : {24'b0, rx_dout};
            2'd2: rd_mux = 32'(div_reg);
            default: rd_mux = {28'b0, ctrl};
        endcase
    end

    logic rx_frame_set, rx_parity_set, rx_overrun_set;
    logic sts_wr;
    assign sts_wr = acc & ~rw & (addr == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_       <= 1'b1;
            rd_data    <= '0;
            div_reg    <= DIV_W'(DEFAULT_DIV);
            ctrl       <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            irq_rx     <= 1'b0;
            irq_tx     <= 1'b0;
        end else begin
            rdy_    <= ~acc;
            rd_data <= (acc & rw) ? rd_mux : 32'b0;
            if (acc && !rw && addr == 2'd2)
                div_reg <= (wr_data[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : wr_data[DIV_W-1:0];
            if (acc && !rw && addr == 2'd3)
                ctrl <= wr_data[3:0];
            // a new error event wins over a same-cycle clear
            if (rx_overrun_set)             rx_overrun <= 1'b1;
            else if (sts_wr && wr_data[3])  rx_overrun <= 1'b0;
            if (rx_frame_set)               frame_err  <= 1'b1;
            else if (sts_wr && wr_data[4])  frame_err  <= 1'b0;
            if (rx_parity_set)              parity_err <= 1'b1;
            else if (sts_wr && wr_data[5])  parity_err <= 1'b0;
            irq_rx <= ctrl[0] & ~rx_empty;
            irq_tx <= ctrl[1] & tx_idle;
        end
    end

    // ---------------- transmitter ----------------
    frame_state_t     tx_state, tx_state_nxt;
    logic [DIV_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_sh;
    logic             tx_par_en, tx_par_bit, tx_load, tx_done;

    assign tx_done = (tx_cnt == '0);
    assign tx_idle = (tx_state == S_IDLE) & tx_empty;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_load      = 1'b0;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_pop = 1'b1; tx_load = 1'b1; tx_state_nxt = S_START;
            end
            S_START: if (tx_done) begin
                tx_load = 1'b1; tx_state_nxt = S_DATA;
            end
            S_DATA: if (tx_done) begin
                tx_load = 1'b1;
                if (tx_bit == 3'd7) tx_state_nxt = tx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tx_done) begin
                tx_load = 1'b1; tx_state_nxt = S_STOP;
            end
            S_STOP: if (tx_done) begin
                if (!tx_empty) begin
                    tx_pop = 1'b1; tx_load = 1'b1; tx_state_nxt = S_START;
                end else begin
                    tx_state_nxt = S_IDLE;
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the
    // state by one clock; every bit still lasts exactly div clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_sh      <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            wr_data_u  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_load)                 tx_cnt <= div_reg - DIV_W'(1);
            else if (tx_state != S_IDLE) tx_cnt <= tx_cnt - DIV_W'(1);
            if (tx_pop) begin
                tx_sh      <= tx_dout;
                tx_bit     <= '0;
                tx_par_en  <= ctrl[2];
                tx_par_bit <= (^tx_dout) ^ ctrl[3];
            end else if (tx_state == S_DATA && tx_done) begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
            end
            case (tx_state)
                S_START:  wr_data_u <= 1'b0;
                S_DATA:   wr_data_u <= tx_sh[0];
                S_PARITY: wr_data_u <= tx_par_bit;
                default:  wr_data_u <= 1'b1;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic             rx_s1, rxd;
    frame_state_t     rx_state, rx_state_nxt;
    logic [DIV_W-1:0] rx_cnt, rx_load_val;
    logic [2:0]       rx_bit;
    logic             rx_par_en, rx_par_odd, rx_par_bit;
    logic             rx_load, rx_begin, rx_shift, rx_par_cap, rx_stop, rx_done, rx_par_bad;

    assign rx_done    = (rx_cnt == '0);
    assign rx_par_bad = rx_par_en & (rx_par_bit != ((^rx_sh) ^ rx_par_odd));

    assign rx_push        = rx_stop & rxd & ~rx_par_bad;
    assign rx_frame_set   = rx_stop & ~rxd;
    assign rx_parity_set  = rx_stop & rxd & rx_par_bad;
    assign rx_overrun_set = rx_push & rx_full;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_load      = 1'b0;
        rx_load_val  = div_reg - DIV_W'(1);
        rx_begin     = 1'b0;
        rx_shift     = 1'b0;
        rx_par_cap   = 1'b0;
        rx_stop      = 1'b0;
        case (rx_state)
            S_IDLE: if (!rxd) begin
                // first sample lands half a bit in, to check the start is real
                rx_begin     = 1'b1;
                rx_load      = 1'b1;
                rx_load_val  = (div_reg >> 1) - DIV_W'(1);
                rx_state_nxt = S_START;
            end
            S_START: if (rx_done) begin
                rx_load      = 1'b1;
                rx_state_nxt = rxd ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_done) begin
                rx_shift = 1'b1;
                rx_load  = 1'b1;
                if (rx_bit == 3'd7) rx_state_nxt = rx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (rx_done) begin
                rx_par_cap   = 1'b1;
                rx_load      = 1'b1;
                rx_state_nxt = S_STOP;
            end
            S_STOP: if (rx_done) begin
                rx_stop      = 1'b1;
                rx_state_nxt = S_IDLE;
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1      <= 1'b1;
            rxd        <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_s1    <= rd_data_u;
            rxd      <= rx_s1;
            rx_state <= rx_state_nxt;
            if (rx_load)                 rx_cnt <= rx_load_val;
            else if (rx_state != S_IDLE) rx_cnt <= rx_cnt - DIV_W'(1);
            if (rx_begin) begin
                rx_bit     <= '0;
                rx_par_en  <= ctrl[2];
                rx_par_odd <= ctrl[3];
            end
            if (rx_shift) begin
                rx_sh  <= {rxd, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
            if (rx_par_cap) rx_par_bit <= rxd;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
    localparam int DEPTH   = 16;
    localparam int INJ_DIV = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rdy_, irq_rx, irq_tx, tx_out, rx_in;
    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;

    assign rx_in = loopback ? tx_out : rx_drv;

    uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DEFAULT_DIV(434)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx),
        .irq_tx(irq_tx), .rd_data_u(rx_in), .wr_data_u(tx_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic last_rdy;

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
        @(negedge clk);
        cs_ = 1'b1; as_ = 1'b1;
        d = rd_data;
        last_rdy = rdy_;
    endtask

    // poll STATUS until (status & mask) == val, bounded by a number of reads
    task automatic wait_status(input string tag, input logic [31:0] mask,
                               input logic [31:0] val, input int budget);
        logic [31:0] s;
        int k;
        k = 0;
        bus_rd(2'd0, s);
        while (((s & mask) != val) && k < budget) begin
            bus_rd(2'd0, s);
            k++;
        end
        check(tag, s & mask, val);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit with_par,
                              input bit par_v, input bit stop_v);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (INJ_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (INJ_DIV) @(negedge clk);
        end
        if (with_par) begin
            rx_drv = par_v;
            repeat (INJ_DIV) @(negedge clk);
        end
        rx_drv = stop_v;
        repeat (INJ_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Independent serial decoder watching the TX line.
    int         mon_div = 434;
    bit         mon_par_en = 1'b0, mon_par_odd = 1'b0;
    logic [7:0] mon_q[$];
    int         mon_bad = 0;

    initial begin
        logic [7:0] b;
        logic       p;
        forever begin
            @(negedge clk);
            if (reset && tx_out === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    b[i] = tx_out;
                end
                if (mon_par_en) begin
                    repeat (mon_div) @(negedge clk);
                    p = tx_out;
                    if (p !== ((^b) ^ mon_par_odd)) mon_bad++;
                end
                repeat (mon_div) @(negedge clk);
                if (tx_out !== 1'b1) mon_bad++;
                mon_q.push_back(b);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_byte, b;
        logic [7:0]  tx_model[$];
        logic [7:0]  rx_model[$];
        int          n, dv, k;
        bit          pe, po;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("reset rdy_", 32'(rdy_), 32'd1);
        check("reset rd_data", rd_data, 32'd0);
        check("reset irq_rx", 32'(irq_rx), 32'd0);
        check("reset irq_tx", 32'(irq_tx), 32'd0);
        check("reset tx line", 32'(tx_out), 32'd1);
        bus_rd(2'd0, d);
        check("reset status", d, 32'h0000_0006);
        check("read rdy_", 32'(last_rdy), 32'd0);
        bus_rd(2'd2, d);
        check("reset divisor", d, 32'd434);
        bus_rd(2'd3, d);
        check("reset ctrl", d, 32'd0);
        bus_wr(2'd2, 32'd1);
        bus_rd(2'd2, d);
        check("divisor floor", d, 32'd4);

        // TX waveform of 0xA5 at div 8
        bus_wr(2'd2, 32'd8);
        mon_div = 8; mon_par_en = 1'b0; mon_par_odd = 1'b0;
        mon_q.delete();
        exp_byte = 8'hA5;
        bus_wr(2'd1, 32'(exp_byte));
        @(negedge clk);
        check("tx line before start", 32'(tx_out), 32'd1);
        @(negedge clk);
        check("tx start bit", 32'(tx_out), 32'd0);
        for (int i = 0; i < 9; i++) begin
            repeat (8) @(negedge clk);
            check($sformatf("tx bit %0d", i), 32'(tx_out),
                  (i < 8) ? 32'(exp_byte[i]) : 32'd1);
        end
        wait_status("tx idle after frame", 32'h4, 32'h4, 40);
        repeat (10) @(negedge clk);
        check("monitor frame count", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) check("monitor byte", 32'(mon_q.pop_front()), 32'hA5);

        // TX FIFO fill while the shifter is busy
        mon_q.delete();
        tx_model.delete();
        bus_wr(2'd1, 32'h11);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            bus_wr(2'd1, 32'(b));
            if (tx_model.size() < DEPTH) tx_model.push_back(b);
        end
        bus_rd(2'd0, d);
        check("tx_count full", 32'(d[23:16]), 32'(DEPTH));
        check("tx_not_full", 32'(d[1]), 32'd0);
        k = 0;
        while (mon_q.size() < 17 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("tx frames out", 32'(mon_q.size()), 32'd17);
        if (mon_q.size() > 0) check("tx warm byte", 32'(mon_q.pop_front()), 32'h11);
        while (mon_q.size() > 0 && tx_model.size() > 0)
            check("tx fifo order", 32'(mon_q.pop_front()), 32'(tx_model.pop_front()));
        repeat (200) @(negedge clk);
        check("no 17th frame", 32'(mon_q.size()), 32'd0);

        // loopback, odd parity, rx interrupt
        loopback = 1'b1;
        mon_par_en = 1'b1; mon_par_odd = 1'b1;
        bus_wr(2'd3, 32'b1100);
        bus_wr(2'd1, 32'h3C);
        wait_status("loop rx_count", 32'h0000_FF00, 32'h0000_0100, 150);
        bus_wr(2'd3, 32'b1101);
        repeat (2) @(negedge clk);
        check("irq_rx high", 32'(irq_rx), 32'd1);
        bus_rd(2'd1, d);
        check("loop data", d, 32'h3C);
        check("irq_rx at pop", 32'(irq_rx), 32'd1);
        @(negedge clk);
        check("irq_rx after pop", 32'(irq_rx), 32'd0);
        bus_rd(2'd0, d);
        check("loop parity_err", 32'(d[5]), 32'd0);
        bus_wr(2'd3, 32'b0010);
        repeat (2) @(negedge clk);
        check("irq_tx idle", 32'(irq_tx), 32'd1);

        // randomized loopback runs
        for (int it = 0; it < 6; it++) begin
            wait_status("pre tx idle", 32'h4, 32'h4, 200);
            repeat (20) @(negedge clk);
            dv = 6 + 2 * $urandom_range(0, 5);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            bus_wr(2'd2, 32'(dv));
            bus_wr(2'd3, {28'b0, po, pe, 2'b00});
            mon_div = dv; mon_par_en = pe; mon_par_odd = po;
            n = $urandom_range(1, 4);
            rx_model.delete();
            mon_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                rx_model.push_back(b);
                bus_wr(2'd1, 32'(b));
            end
            wait_status("rand rx_count", 32'h0000_FF00, 32'(n) << 8, n * 11 * dv / 2 + 60);
            for (int i = 0; i < n; i++) begin
                bus_rd(2'd1, d);
                check("rand loop data", d, 32'(rx_model.pop_front()));
            end
            bus_rd(2'd0, d);
            check("rand flags", d & 32'h38, 32'h0);
        end
        check("tx monitor errors", 32'(mon_bad), 32'd0);

        // injected frames: overrun
        wait_status("tx idle before inject", 32'h4, 32'h4, 200);
        loopback = 1'b0;
        bus_wr(2'd2, 32'(INJ_DIV));
        bus_wr(2'd3, 32'd0);
        rx_model.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b0, 1'b0, 1'b1);
            if (rx_model.size() < DEPTH) rx_model.push_back(b);
        end
        bus_rd(2'd0, d);
        check("rx_count full", 32'(d[15:8]), 32'(DEPTH));
        check("rx_overrun set", 32'(d[3]), 32'd1);
        bus_wr(2'd0, 32'h08);
        bus_rd(2'd0, d);
        check("rx_overrun cleared", 32'(d[3]), 32'd0);
        while (rx_model.size() > 0) begin
            bus_rd(2'd1, d);
            check("rx fifo order", d, 32'(rx_model.pop_front()));
        end
        bus_rd(2'd1, d);
        check("empty rx read", d, 32'd0);

        // parity error, even parity, wrong parity bit
        bus_wr(2'd3, 32'b0100);
        send_frame(8'h5A, 1'b1, ~(^8'h5A), 1'b1);
        bus_rd(2'd0, d);
        check("parity_err set", 32'(d[5]), 32'd1);
        check("parity rx_count", 32'(d[15:8]), 32'd0);
        bus_wr(2'd0, 32'h38);
        bus_wr(2'd3, 32'd0);

        // frame error
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        bus_rd(2'd0, d);
        check("frame_err set", 32'(d[4]), 32'd1);
        check("frame rx_count", 32'(d[15:8]), 32'd0);
        bus_wr(2'd0, 32'h38);

        // quarter-bit glitch
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (INJ_DIV / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * INJ_DIV) @(negedge clk);
        bus_rd(2'd0, d);
        check("glitch status", d, 32'h0000_0006);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
